// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the 16-bit shift-add multiplier.
// Also holds the 4-bit carry-lookahead helper used by the adder.
package seq_mult_pkg;

   localparam int WIDTH       = 16;
   localparam int CALC_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {c4, c3, c2, c1} for one lookahead block.
   function automatic logic [3:0] cla4(
      input logic [3:0] g,
      input logic [3:0] p,
      input logic       c0
   );
      logic [3:0] c;
      c[0] = g[0] | (p[0] & c0);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/seq_multiplier_16bit_cla.sv
// Two-level 16-bit carry-lookahead adder: four 4-bit blocks
// whose group generate/propagate feed a second lookahead stage.
module CLA_16bit_Adder
   import seq_mult_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [3:0]  gc;
   logic [3:0]  t;
   logic        ci;

   always_comb begin
      g  = a & b;
      p  = a ^ b;
      c  = '0;
      gg = '0;
      gp = '0;
      t  = '0;
      ci = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t     = cla4(g[4*i +: 4], p[4*i +: 4], 1'b0);
         gg[i] = t[3];
         gp[i] = &p[4*i +: 4];
      end
      gc = cla4(gg, gp, cin);
      for (int i = 0; i < 4; i++) begin
         ci = (i == 0) ? cin : gc[i-1];
         t  = cla4(g[4*i +: 4], p[4*i +: 4], ci);
         c[4*i]           = ci;
         c[4*i + 1 +: 3]  = t[2:0];
      end
      sum  = p ^ c;
      cout = gc[3];
   end

endmodule

// File: rtl/seq_multiplier_16bit.sv
// Sequential shift-add unsigned multiplier: one multiplier bit
// per cycle through a single CLA, 18 cycles per operation.
module seq_multiplier_16bit
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = seq_mult_pkg::WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               cout;

   assign addend = mplr_q[0] ? mcand_q : '0;

   CLA_16bit_Adder u_cla (
      .a    (acc_hi_q),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_hi_d  = acc_hi_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = a;
               mplr_d   = b;
               acc_hi_d = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            // 33-bit right shift of {cout, sum, mplr}
            acc_hi_d = {cout, sum[WIDTH-1:1]};
            mplr_d   = {sum[0], mplr_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(CALC_CYCLES - 1)) begin
               product_d = {cout, sum, mplr_q[WIDTH-1:1]};
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_hi_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_hi_q  <= acc_hi_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_16bit.sv
// Directed vector table plus hand sequences for the
// shift-add multiplier; back-to-back random regression at the end.
module tb_seq_multiplier_16bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int n_checks;
   int n_fail;
   int cyc;

   seq_multiplier_16bit #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] want;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
      end
   endtask

   // Called at a negedge; start sampled at the next rising edge.
   // a/b are scrambled after acceptance. Returns at the negedge
   // after the done pulse.
   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                         input bit poke_done, input bit full,
                         output logic [31:0] p, output int lat);
      bit seen;
      seen  = 0;
      lat   = 0;
      p     = '0;
      a     = ia;
      b     = ib;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            a     = 16'($urandom);
            b     = 16'($urandom);
            if (full) check("busy_after_start", 32'(busy), 32'd1);
         end
         if (done) begin
            seen = 1;
            lat  = k;
            p    = product;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got none expected done within 40");
      end
      if (poke_done) begin
         start = 1'b1;
         a     = 16'h0003;
         b     = 16'h0003;
      end
      @(negedge clk);
      start = 1'b0;
      if (full) begin
         check("done_width", 32'(done), 32'd0);
         check("busy_after_done", 32'(busy), 32'd0);
      end
   endtask

   logic [31:0] p;
   logic [31:0] prev;
   logic [31:0] want;
   logic [15:0] ra;
   logic [15:0] rb;
   int          lat;
   int          ndone;
   int          last_done;
   int          gap;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;

      vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
      vecs[3] = '{16'h0000, 16'hABCD, 32'h0000_0000};
      vecs[4] = '{16'h0001, 16'h0001, 32'h0000_0001};
      vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
      vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000};
      vecs[7] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};
      vecs[8] = '{16'h1234, 16'h5678, 32'h0626_0060};
      vecs[9] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE};

      // reset state, with start held high to show it is ignored
      repeat (2) @(negedge clk);
      start = 1'b1;
      a     = 16'h0007;
      b     = 16'h0007;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", product, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, 0, 1, p, lat);
         check($sformatf("vec%0d_product", i), p, vecs[i].want);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d_hold", i), product, vecs[i].want);
      end

      // second start mid-CALC is ignored; old product held meanwhile
      prev  = product;
      ndone = 0;
      p     = '0;
      lat   = 0;
      a     = 16'd7;
      b     = 16'd9;
      start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 4) begin
            start = 1'b1;
            a     = 16'd1;
            b     = 16'd1;
         end
         if (k == 5) start = 1'b0;
         if (k == 3) check("ignore_hold_prev", product, prev);
         if (done) begin
            ndone++;
            p   = product;
            lat = k;
         end
      end
      check("ignore_product", p, 32'h0000_003F);
      check("ignore_ndone", 32'(ndone), 32'd1);
      check("ignore_latency", 32'(lat), 32'd17);

      // start during DONE is ignored
      run_op(16'd4, 16'd4, 1, 1, p, lat);
      check("poke_product", p, 32'd16);
      repeat (2) @(negedge clk);
      check("poke_busy", 32'(busy), 32'd0);
      check("poke_hold", product, 32'd16);

      // reset mid-CALC aborts
      a     = 16'h00FF;
      b     = 16'h0101;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_product", product, 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      run_op(16'd2, 16'd3, 0, 1, p, lat);
      check("after_rst_product", p, 32'd6);
      check("after_rst_latency", 32'(lat), 32'd17);

      // back-to-back random regression
      last_done = -1;
      for (int n = 0; n < 1000; n++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         want = 32'(ra) * 32'(rb);
         run_op(ra, rb, 0, 0, p, lat);
         check("rand_product", p, want);
         gap = cyc - last_done;
         if (last_done >= 0) check("rand_spacing", 32'(gap), 32'd18);
         last_done = cyc;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_multiplier_16bit.md
SEQ_MULTIPLIER_16BIT -- requirements
Module: seq_multiplier_16bit

Interface
REQ-001 Parameter WIDTH, default 16, operand width; the block SHALL be correct for 16 only, and other values are unsupported.
REQ-002 clk  input  1  rising-edge clock; the block SHALL be synchronous to clk only.
REQ-003 rst  input  1  reset; it SHALL be asynchronous and active-high.
REQ-004 start  input  1  request; it SHALL be sampled high in IDLE to accept the operands.
REQ-005 a  input  16  multiplicand, unsigned; it SHALL be sampled on the edge that accepts start.
REQ-006 b  input  16  multiplier, unsigned; it SHALL be sampled on the edge that accepts start.
REQ-007 busy  output  1  SHALL be high while state is CALC or DONE.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking product valid.
REQ-009 product  output  32  a*b, unsigned; it SHALL be registered.

Function
REQ-010 The FSM SHALL have the states IDLE, CALC and DONE, and no other reachable state.
REQ-011 In IDLE with start=1, the block SHALL latch mcand=a and mplr=b, clear acc_hi[15:0] and cnt[4:0], and go to CALC.
REQ-012 Each CALC cycle SHALL evaluate sum,cout = acc_hi + (mplr[0] ? mcand : 0) through the 16-bit CLA adder with cin=0.
REQ-013 Each CALC cycle SHALL register {acc_hi, mplr} <= {cout, sum, mplr[15:1]}, a 33-bit right shift that consumes one multiplier bit per cycle.
REQ-014 Each CALC cycle SHALL increment cnt; after the 16th CALC cycle (cnt reaches 16) the FSM SHALL go to DONE.
REQ-015 On entry to DONE, the block SHALL load product <= {acc_hi, mplr} and assert done for exactly one cycle.
REQ-016 The FSM SHALL go from DONE to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge N, done SHALL be high during the cycle after edge N+16 and product SHALL be valid from that cycle.
REQ-018 product SHALL hold its value until the next DONE entry; a new start SHALL NOT disturb product before its own completion.
REQ-019 start while busy=1, including in DONE, SHALL be ignored with no effect on state, operands or outputs.
REQ-020 Back-to-back: start asserted in the cycle after done SHALL be accepted, giving one operation per 18 cycles.
REQ-021 The arithmetic SHALL never overflow: 0xFFFF*0xFFFF=0xFFFE0001 fits in 32 bits, and the adder cout SHALL be captured on every cycle.
REQ-022 Changes on a and b after acceptance SHALL NOT affect the result.

Reset
REQ-023 While rst=1, the block SHALL be in state IDLE with busy=0, done=0, product=0, acc_hi=0, mplr=0, mcand=0 and cnt=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately, with no done pulse and product=0.
REQ-025 After rst deasserts, the first clk edge with start=1 SHALL be accepted normally.

Structure
REQ-026 A shared package seq_mult_pkg SHALL hold the WIDTH constant, the state typedef (IDLE/CALC/DONE) and the CALC cycle count constant (16).
REQ-027 The block SHALL contain exactly one sub-module: CLA_16bit_Adder, instanced once, with cin tied to 0, sum feeding acc_hi and cout feeding the shift MSB.
REQ-028 No other adder SHALL be inferred for the product; only cnt may use a native incrementer.

Verification
REQ-029 a=3, b=5, start for one cycle -> done high 17 cycles later, product=0x0000000F, busy low the following cycle.
REQ-030 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, which exercises cout on every CALC cycle.
REQ-031 a=0x1234, b=0 and a=0, b=0xABCD -> product=0x00000000 and done pulses once in each case.
REQ-032 Start with a=7, b=9, then start again with a=1, b=1 at cycle 5 -> the second start is ignored, product=0x0000003F, and only one done pulse occurs.
REQ-033 Start with a=0x00FF, b=0x0101, then assert rst at cycle 8 -> busy=0, product=0 and no done pulse; a subsequent start with a=2, b=3 -> product=6.
REQ-034 A random regression of 1000 back-to-back operations with start asserted in the cycle after each done -> every product SHALL equal a*b, and the spacing between done pulses SHALL be 18 cycles.
